mips_exec_unit: RTL and testbench
=================================

MIPS_EXEC_UNIT -- requirements
Module: mips_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width (16..64).
REQ-002 SHALL have parameter MUL_LAT, default 3, multiply latency in cycles (1..8).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1, the issue handshake; transfer occurs when both are high.
REQ-006 SHALL have ports in_opcode in 6, in_rs_data in DATA_W, in_rt_data in DATA_W, in_imm in 16, in_rd in 5, and in_pc in DATA_W, which is PC+4 of the issued instruction.
REQ-007 SHALL have port flush  in  1, which kills all in-flight work.
REQ-008 SHALL have ports out_valid out 1 / out_ready in 1, the result handshake.
REQ-009 SHALL have output ports out_result DATA_W, out_rd 5, out_store_data DATA_W, out_wb_en 1, out_mem_rd 1, out_mem_wr 1, out_misalign 1, br_taken 1, br_target DATA_W, halt 1 and illegal 1.

Function
REQ-010 SHALL decode opcodes 0-17 as ADD, ADDI, SUB, SUBI, MUL, MULI, OR, ORI, AND, ANDI, XOR, XORI, LWD, STW, BZ, BEQ, JR, HALT.
REQ-011 SHALL sign-extend in_imm to DATA_W for every I-type opcode, including ORI, ANDI and XORI.
REQ-012 SHALL compute arithmetic modulo 2^DATA_W, with no overflow flag; MUL and MULI return the low DATA_W bits of the signed product.
REQ-013 SHALL, for LWD and STW, set out_result = (rs+simm)>>2 (word index), out_misalign = |(rs+simm)[1:0]|, and out_store_data = rt.
REQ-014 SHALL set out_mem_rd=1 for LWD only and out_mem_wr=1 for STW only.
REQ-015 SHALL set out_wb_en=1 for ALU ops and LWD; it SHALL be 0 for STW, BZ, BEQ, JR, HALT and illegal opcodes.
REQ-016 SHALL resolve branches as follows: BZ is taken if rs==0; BEQ is taken if rs==rt; when taken, br_target = in_pc + (simm<<2), otherwise br_target = in_pc.
REQ-017 SHALL treat JR as always taken, with br_target = rs.
REQ-018 SHALL treat opcodes 18-63 as illegal, emitting one output beat with illegal=1 and all enables 0.
REQ-019 SHALL use FSM states IDLE, MUL_BUSY, HOLD and HALTED.
REQ-020 SHALL, in IDLE, hold in_ready=1 and issue a non-MUL op with 1-cycle latency: out_valid rises the cycle after the transfer.
REQ-021 SHALL, on a MUL/MULI transfer, enter MUL_BUSY, hold in_ready=0, and present out_valid exactly MUL_LAT cycles after the transfer.
REQ-022 SHALL hold the output register stable while out_valid=1 and out_ready=0 (HOLD state), with in_ready=0.
REQ-023 SHALL, in a cycle where out_valid&&out_ready and in_valid are both high, accept the new issue (back-to-back throughput of 1 per cycle for non-MUL ops).
REQ-024 SHALL, on HALT, emit one beat with halt=1 and then enter HALTED; in HALTED, in_ready=0 and out_valid=0 until reset.
REQ-025 SHALL make flush take priority over every other event: the next state is IDLE, out_valid=0, any multiply in progress is discarded, and an issue in the same cycle is dropped.
REQ-026 SHALL keep br_taken, halt and illegal qualified by out_valid, and drive them 0 whenever out_valid=0.

Reset
REQ-027 SHALL, on rst, immediately and asynchronously set the FSM to IDLE, clear all output registers, and clear the multiply counter.
REQ-028 SHALL drive in_ready=1 after rst deasserts.
REQ-029 SHALL abandon any mid-multiply or HALTED state on rst, with no output beat emitted.

Verification
REQ-030 ADDI with rs=5, imm=0xFFFD, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=2, out_rd=3, out_wb_en=1.
REQ-031 MUL with rs=-4, rt=6, MUL_LAT=3 -> in_ready=0 for 3 cycles, then out_result=0xFFFFFFE8; a back-to-back ADD is accepted only after that.
REQ-032 BEQ with rs=rt=7, in_pc=0x20, imm=0xFFFE -> br_taken=1, br_target=0x18; with rs=7, rt=8 -> br_taken=0, br_target=0x20.
REQ-033 STW with rs=0x10, imm=6, rt=0xAB -> out_result=5, out_misalign=1, out_mem_wr=1, out_store_data=0xAB, out_wb_en=0.
REQ-034 Hold out_ready=0 for 4 cycles after an XOR -> outputs stable, in_ready=0; then flush during a 2nd-cycle MUL -> out_valid stays 0 and in_ready=1 next cycle.
REQ-035 HALT followed by in_valid=1 -> one beat with halt=1, then in_ready=0 indefinitely; asserting rst mid-HALTED -> IDLE, in_ready=1.

Source files
------------

// File: rtl/mips_exec_unit_if.sv
// Issue/result bus of the MIPS execute unit.
// The slave side is the execute unit; the master side is the pipeline driving it.
interface mips_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [15:0]       in_imm;
    logic [4:0]        in_rd;
    logic [DATA_W-1:0] in_pc;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_store_data;
    logic              out_wb_en;
    logic              out_mem_rd;
    logic              out_mem_wr;
    logic              out_misalign;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
    logic              halt;
    logic              illegal;

    modport slave (
        input  in_valid, in_opcode, in_rs_data, in_rt_data, in_imm, in_rd, in_pc,
        input  flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_store_data, out_wb_en,
        output out_mem_rd, out_mem_wr, out_misalign, br_taken, br_target, halt, illegal
    );

    modport master (
        output in_valid, in_opcode, in_rs_data, in_rt_data, in_imm, in_rd, in_pc,
        output flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_store_data, out_wb_en,
        input  out_mem_rd, out_mem_wr, out_misalign, br_taken, br_target, halt, illegal
    );
endinterface

// File: rtl/mips_exec_unit.sv
// Single-issue MIPS execute stage: 1-cycle ALU/memory/branch ops, a MUL_LAT-cycle
// multiply, one registered result beat with valid/ready backpressure, and halt.
module mips_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input logic             clk,
    input logic             rst,
    mips_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, HOLD = 2'd2, HALTED = 2'd3} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [4:0]        rd;
        logic [DATA_W-1:0] sdata;
        logic              wb;
        logic              mrd;
        logic              mwr;
        logic              mis;
        logic              brt;
        logic [DATA_W-1:0] btgt;
        logic              halt;
        logic              ill;
    } beat_t;

    localparam logic [5:0] OP_ADD  = 6'd0,  OP_ADDI = 6'd1,  OP_SUB  = 6'd2,  OP_SUBI = 6'd3;
    localparam logic [5:0] OP_MUL  = 6'd4,  OP_MULI = 6'd5,  OP_OR   = 6'd6,  OP_ORI  = 6'd7;
    localparam logic [5:0] OP_AND  = 6'd8,  OP_ANDI = 6'd9,  OP_XOR  = 6'd10, OP_XORI = 6'd11;
    localparam logic [5:0] OP_LWD  = 6'd12, OP_STW  = 6'd13, OP_BZ   = 6'd14, OP_BEQ  = 6'd15;
    localparam logic [5:0] OP_JR   = 6'd16, OP_HALT = 6'd17;
    localparam logic [3:0] LAT_M1  = 4'(MUL_LAT - 1);

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return DATA_W'($signed(v));
    endfunction

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     vld_q, vld_d;
    beat_t                    beat_q, beat_d;
    logic signed [DATA_W-1:0] mul_q, mul_d;
    logic [4:0]               mul_rd_q, mul_rd_d;

    logic signed [DATA_W-1:0] rs, rt, simm, opb, ea, prod;
    logic                     is_mul, in_ready_w, accept;
    beat_t                    dec_beat, mul_beat;

    assign rs     = bus.in_rs_data;
    assign rt     = bus.in_rt_data;
    assign simm   = sext16(bus.in_imm);
    // Odd ALU opcodes are the immediate forms of the even ones.
    assign opb    = (bus.in_opcode[0] && bus.in_opcode <= OP_XORI) ? simm : rt;
    assign ea     = rs + simm;
    assign prod   = rs * opb;
    assign is_mul = (bus.in_opcode == OP_MUL) || (bus.in_opcode == OP_MULI);

    always_comb begin
        dec_beat      = '0;
        dec_beat.rd   = bus.in_rd;
        dec_beat.btgt = bus.in_pc;
        case (bus.in_opcode)
            OP_ADD, OP_ADDI: begin dec_beat.res = rs + opb; dec_beat.wb = 1'b1; end
            OP_SUB, OP_SUBI: begin dec_beat.res = rs - opb; dec_beat.wb = 1'b1; end
            OP_MUL, OP_MULI: begin dec_beat.res = prod;     dec_beat.wb = 1'b1; end
            OP_OR,  OP_ORI:  begin dec_beat.res = rs | opb; dec_beat.wb = 1'b1; end
            OP_AND, OP_ANDI: begin dec_beat.res = rs & opb; dec_beat.wb = 1'b1; end
            OP_XOR, OP_XORI: begin dec_beat.res = rs ^ opb; dec_beat.wb = 1'b1; end
            OP_LWD, OP_STW: begin
                dec_beat.res   = ea >> 2;
                dec_beat.mis   = |ea[1:0];
                dec_beat.sdata = rt;
                dec_beat.wb    = (bus.in_opcode == OP_LWD);
                dec_beat.mrd   = (bus.in_opcode == OP_LWD);
                dec_beat.mwr   = (bus.in_opcode == OP_STW);
            end
            OP_BZ, OP_BEQ: begin
                dec_beat.brt = (bus.in_opcode == OP_BZ) ? (rs == '0) : (rs == rt);
                if (dec_beat.brt) dec_beat.btgt = bus.in_pc + (simm <<< 2);
            end
            OP_JR: begin dec_beat.brt = 1'b1; dec_beat.btgt = rs; end
            OP_HALT: dec_beat.halt = 1'b1;
            default: dec_beat.ill  = 1'b1;
        endcase
    end

    always_comb begin
        mul_beat     = '0;
        mul_beat.res = mul_q;
        mul_beat.rd  = mul_rd_q;
        mul_beat.wb  = 1'b1;
    end

    // A pending halt beat blocks issue so nothing slips in ahead of HALTED.
    assign in_ready_w = (state_q == IDLE) && (!vld_q || (bus.out_ready && !beat_q.halt));
    assign accept     = bus.in_valid && in_ready_w && !bus.flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        beat_d   = beat_q;
        mul_d    = mul_q;
        mul_rd_d = mul_rd_q;
        if (bus.flush) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vld_q && bus.out_ready) vld_d = 1'b0;
                    if (vld_q && bus.out_ready && beat_q.halt) begin
                        state_d = HALTED;
                    end else if (accept) begin
                        if (is_mul) begin
                            state_d  = MUL_BUSY;
                            mul_d    = prod;
                            mul_rd_d = bus.in_rd;
                            if (MUL_LAT == 1) begin
                                beat_d = dec_beat;
                                vld_d  = 1'b1;
                            end else begin
                                cnt_d  = LAT_M1;
                            end
                        end else begin
                            beat_d = dec_beat;
                            vld_d  = 1'b1;
                        end
                    end else if (vld_q && !bus.out_ready) begin
                        state_d = HOLD;
                    end
                end
                // The multiply result beat is presented while still in MUL_BUSY.
                MUL_BUSY: begin
                    if (vld_q) begin
                        if (bus.out_ready) begin
                            vld_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (cnt_q <= 4'd1) begin
                        beat_d = mul_beat;
                        vld_d  = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        vld_d   = 1'b0;
                        state_d = beat_q.halt ? HALTED : IDLE;
                    end
                end
                HALTED:  vld_d   = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            beat_q   <= '0;
            mul_q    <= '0;
            mul_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            beat_q   <= beat_d;
            mul_q    <= mul_d;
            mul_rd_q <= mul_rd_d;
        end
    end

    assign bus.in_ready       = in_ready_w;
    assign bus.out_valid      = vld_q;
    assign bus.out_result     = beat_q.res;
    assign bus.out_rd         = beat_q.rd;
    assign bus.out_store_data = beat_q.sdata;
    assign bus.out_wb_en      = beat_q.wb;
    assign bus.out_mem_rd     = beat_q.mrd;
    assign bus.out_mem_wr     = beat_q.mwr;
    assign bus.out_misalign   = beat_q.mis;
    assign bus.br_taken       = vld_q & beat_q.brt;
    assign bus.br_target      = beat_q.btgt;
    assign bus.halt           = vld_q & beat_q.halt;
    assign bus.illegal        = vld_q & beat_q.ill;
endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed scenarios plus random traffic, with a
// scoreboard fed at issue time and drained by an output monitor.
module tb_mips_exec_unit;
    localparam int DW = 32;
    localparam int ML = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_exec_unit_if #(.DATA_W(DW)) bus();
    mips_exec_unit #(.DATA_W(DW), .MUL_LAT(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          op;
        logic [31:0] res, sdata, tgt;
        logic [4:0]  rd;
        bit          wb, mrd, mwr, mis, brt, hlt, ill, c_res, c_mem, c_tgt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rnd_rdy = 1'b0;

    function automatic exp_t model(input int op, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic [4:0] rd, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] si, b, ea;
        longint      p;
        e = '{default: 0};
        e.op = op;
        e.rd = rd;
        si = 32'(int'($signed(imm)));
        b  = (op % 2 == 1) ? si : rt;
        if (op <= 11) begin
            e.wb = 1; e.c_res = 1;
            case (op / 2)
                0: e.res = rs + b;
                1: e.res = rs - b;
                2: begin p = longint'($signed(rs)) * longint'($signed(b)); e.res = p[31:0]; end
                3: e.res = rs | b;
                4: e.res = rs & b;
                default: e.res = rs ^ b;
            endcase
        end else if (op == 12 || op == 13) begin
            ea = rs + si;
            e.res = ea / 4; e.mis = (ea % 4) != 0; e.sdata = rt;
            e.c_res = 1; e.c_mem = 1;
            e.wb = (op == 12); e.mrd = (op == 12); e.mwr = (op == 13);
        end else if (op == 14 || op == 15) begin
            e.brt = (op == 14) ? (rs == 0) : (rs == rt);
            e.tgt = e.brt ? pc + si * 4 : pc;
            e.c_tgt = 1;
        end else if (op == 16) begin
            e.brt = 1; e.tgt = rs; e.c_tgt = 1;
        end else if (op == 17) begin
            e.hlt = 1;
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic check_beat();
        exp_t e;
        bit   ok;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got result %0h with no outstanding issue", bus.out_result);
            return;
        end
        e  = q.pop_front();
        ok = (bus.out_wb_en === e.wb) && (bus.out_mem_rd === e.mrd) && (bus.out_mem_wr === e.mwr) &&
             (bus.br_taken === e.brt) && (bus.halt === e.hlt) && (bus.illegal === e.ill);
        if (e.wb)    ok = ok && (bus.out_rd === e.rd);
        if (e.c_res) ok = ok && (bus.out_result === e.res);
        if (e.c_mem) ok = ok && (bus.out_store_data === e.sdata) && (bus.out_misalign === e.mis);
        if (e.c_tgt) ok = ok && (bus.br_target === e.tgt);
        if (!ok) begin
            bad++;
            $display("FAIL beat op=%0d: got res=%h rd=%0d sd=%h tgt=%h flags=%b want res=%h rd=%0d sd=%h tgt=%h flags=%b",
                     e.op, bus.out_result, bus.out_rd, bus.out_store_data, bus.br_target,
                     {bus.out_wb_en, bus.out_mem_rd, bus.out_mem_wr, bus.out_misalign, bus.br_taken, bus.halt, bus.illegal},
                     e.res, e.rd, e.sdata, e.tgt, {e.wb, e.mrd, e.mwr, e.mis, e.brt, e.hlt, e.ill});
        end
    endtask

    // Output monitor / scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) check_beat();
            if (!bus.out_valid) chk("unqualified_flags", {bus.br_taken, bus.halt, bus.illegal}, 0);
            if (bus.flush) q.delete();
            else if (bus.in_valid && bus.in_ready)
                q.push_back(model(int'(bus.in_opcode), bus.in_rs_data, bus.in_rt_data,
                                  bus.in_imm, bus.in_rd, bus.in_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic set_in(input int op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [4:0] rd, input logic [31:0] pc);
        bus.in_opcode  = 6'(op);
        bus.in_rs_data = rs;
        bus.in_rt_data = rt;
        bus.in_imm     = imm;
        bus.in_rd      = rd;
        bus.in_pc      = pc;
        bus.in_valid   = 1'b1;
    endtask

    // Returns one cycle after the transfer edge, at edge+1.
    task automatic issue(input int op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [4:0] rd, input logic [31:0] pc);
        bit ok = 1'b0;
        set_in(op, rs, rt, imm, rd, pc);
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL issue_timeout op=%0d: in_ready got 0 want 1", op);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rs_data = '0; bus.in_rt_data = '0;
        bus.in_imm = '0; bus.in_rd = '0; bus.in_pc = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_flags", {bus.br_taken, bus.halt, bus.illegal}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.in_ready, 1);
        tick();

        issue(1, 5, 0, 16'hFFFD, 3, 0);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_result", bus.out_result, 2);
        chk("addi_rd", bus.out_rd, 3);
        chk("addi_wb", bus.out_wb_en, 1);
        tick();

        issue(4, 32'hFFFFFFFC, 6, 0, 7, 0);
        set_in(0, 10, 20, 0, 9, 0);
        for (int c = 1; c <= ML; c++) begin
            @(negedge clk);
            chk($sformatf("mul_ready_c%0d", c), bus.in_ready, 0);
            chk($sformatf("mul_valid_c%0d", c), bus.out_valid, 64'(c == ML));
            if (c == ML) chk("mul_result", bus.out_result, 32'hFFFFFFE8);
            tick();
        end
        @(negedge clk);
        chk("add_after_mul_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("add_after_mul_valid", bus.out_valid, 1);
        chk("add_after_mul_result", bus.out_result, 30);
        tick();

        issue(15, 7, 7, 16'hFFFE, 0, 32'h20);
        chk("beq_taken", bus.br_taken, 1);
        chk("beq_target", bus.br_target, 32'h18);
        chk("beq_wb", bus.out_wb_en, 0);
        tick();
        issue(15, 7, 8, 16'hFFFE, 0, 32'h20);
        chk("beq_not_taken", bus.br_taken, 0);
        chk("beq_nt_target", bus.br_target, 32'h20);
        tick();

        issue(13, 32'h10, 32'hAB, 16'd6, 0, 0);
        chk("stw_index", bus.out_result, 5);
        chk("stw_misalign", bus.out_misalign, 1);
        chk("stw_mem_wr", bus.out_mem_wr, 1);
        chk("stw_mem_rd", bus.out_mem_rd, 0);
        chk("stw_data", bus.out_store_data, 32'hAB);
        chk("stw_wb", bus.out_wb_en, 0);
        tick();

        bus.out_ready = 1'b0;
        issue(10, 32'hF0F0, 32'h0FF0, 0, 4, 0);
        set_in(0, 1, 2, 0, 5, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_c%0d", c), bus.out_valid, 1);
            chk($sformatf("hold_result_c%0d", c), bus.out_result, 32'hFF00);
            chk($sformatf("hold_ready_c%0d", c), bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", bus.in_ready, 0);
        tick();
        @(negedge clk);
        chk("after_hold_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("after_hold_result", bus.out_result, 3);
        tick();

        issue(5, 3, 0, 16'd2, 6, 0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", bus.in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("flush_no_beat_c%0d", c), bus.out_valid, 0);
            tick();
        end
        set_in(0, 4, 4, 0, 2, 0);
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_drops_issue", bus.out_valid, 0);
        tick();

        rnd_rdy = 1'b1;
        for (int n = 0; n < 250; n++) begin
            int          op;
            logic [31:0] a, b;
            op = int'($urandom_range(0, 16));
            if ($urandom_range(0, 9) == 0) op = int'($urandom_range(18, 63));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = 0;
                1: b = a;
                default: ;
            endcase
            issue(op, a, b, 16'($urandom), 5'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 29) == 0) begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
            end
        end
        rnd_rdy = 1'b0;
        bus.out_ready = 1'b1;
        begin
            bit drained = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (q.size() == 0 && !bus.out_valid) begin drained = 1'b1; break; end
                tick();
            end
            if (!drained) begin
                total++; bad++;
                $display("FAIL drain_timeout: %0d beats still outstanding, want 0", q.size());
            end
        end
        tick();

        issue(4, 2, 3, 0, 1, 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_mul_ready", bus.in_ready, 1);
        chk("rst_mid_mul_valid", bus.out_valid, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < ML + 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mul_no_beat_c%0d", c), bus.out_valid, 0);
            tick();
        end

        issue(17, 0, 0, 0, 0, 0);
        set_in(0, 1, 2, 0, 8, 0);
        chk("halt_beat_valid", bus.out_valid, 1);
        chk("halt_beat_flag", bus.halt, 1);
        chk("halt_beat_wb", bus.out_wb_en, 0);
        @(negedge clk);
        chk("halt_beat_ready", bus.in_ready, 0);
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("halted_valid_c%0d", c), bus.out_valid, 0);
            chk($sformatf("halted_ready_c%0d", c), bus.in_ready, 0);
            tick();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("halted_rst_ready", bus.in_ready, 1);
        chk("halted_rst_valid", bus.out_valid, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_halt_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("post_halt_valid", bus.out_valid, 1);
        chk("post_halt_result", bus.out_result, 3);
        tick();
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
